// File: rtl/keypad_reader.sv
// keypad_reader: debounces four active-low buttons, latches press events,
// queues press order in an 8-deep FIFO and exposes it on the bus window.
module keypad_reader #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  en,
  input  logic [3:0]            buttons_n,
  output logic [15:0]           q,
  output logic                  irq
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CTR_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [CW-1:0] r_ctr [4];
  logic [3:0]    r_stable;
  logic [3:0]    r_stable_d;
  logic [3:0]    r_flag;
  logic [3:0]    r_pend;
  logic [1:0]    r_mem [8];
  logic [2:0]    r_wr;
  logic [2:0]    r_rd;
  logic [3:0]    r_count;
  logic          r_ovf;

  logic [3:0]    w_sync;
  logic [2:0]    w_sel;
  logic          w_rd;
  logic          w_wr;
  logic          w_pop;
  logic          w_flush;
  logic [3:0]    w_w1c;
  logic [3:0]    w_press;
  logic          w_have;
  logic [1:0]    w_idx;
  logic [3:0]    w_pend_clr;
  logic          w_push;
  logic          w_drop;
  logic [3:0]    w_count_nxt;
  logic [15:0]   w_rdata;
  logic          w_unused_bits;

  assign w_sync     = ~r_sync2;
  assign w_sel      = addr[10:8];
  assign w_rd       = en & ~we;
  assign w_wr       = en & we;
  assign w_pop      = w_rd && (w_sel == 3'd3) && (r_count != 4'd0);
  assign w_flush    = w_wr && (w_sel == 3'd2) && data[0];
  assign w_w1c      = (w_wr && (w_sel == 3'd1)) ? data[3:0] : 4'b0000;
  assign w_press    = r_stable & ~r_stable_d;
  assign w_have     = |r_pend;
  assign w_pend_clr = w_have ? (4'b0001 << w_idx) : 4'b0000;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push     = w_have && !w_flush && (!r_count[3] || w_pop);
  assign w_drop     = w_have && !w_flush && r_count[3] && !w_pop;

  assign w_unused_bits = ^{data[DATA_WIDTH-1:4], addr[ADDR_WIDTH-1:11], addr[7:0]};

  // Lowest pending button index is queued first.
  always_comb begin
    w_idx = 2'd0;
    if      (r_pend[0]) w_idx = 2'd0;
    else if (r_pend[1]) w_idx = 2'd1;
    else if (r_pend[2]) w_idx = 2'd2;
    else if (r_pend[3]) w_idx = 2'd3;
  end

  // Next FIFO occupancy; flush overrides any push.
  always_comb begin
    w_count_nxt = r_count;
    if (w_flush)               w_count_nxt = '0;
    else if (w_push && !w_pop) w_count_nxt = r_count + 4'd1;
    else if (w_pop && !w_push) w_count_nxt = r_count - 4'd1;
  end

  // Register window read mux.
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      3'd0:    w_rdata = {12'b0, r_stable};
      3'd1:    w_rdata = {12'b0, r_flag};
      3'd2:    w_rdata = {11'b0, r_ovf, r_count};
      3'd3:    w_rdata = w_pop ? {1'b1, 13'b0, r_mem[r_rd]} : 16'h0000;
      default: w_rdata = 16'h0000;
    endcase
  end

  // Two-flop synchronizer; idle level is released (high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= buttons_n;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debounce: a new level must persist DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int unsigned i = 0; i < 4; i++) r_ctr[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_sync[i] == r_stable[i]) begin
          r_ctr[i] <= '0;
        end else if (r_ctr[i] == CTR_MAX) begin
          r_stable[i] <= w_sync[i];
          r_ctr[i]    <= '0;
        end else begin
          r_ctr[i] <= r_ctr[i] + 1'b1;
        end
      end
    end
  end

  // Press edge detection; a new press beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_d <= '0;
      r_flag     <= '0;
      r_pend     <= '0;
    end else begin
      r_stable_d <= r_stable;
      r_flag     <= (r_flag & ~w_w1c) | w_press;
      r_pend     <= (r_pend & ~w_pend_clr) | w_press;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_idx;
  end

  // FIFO pointers, occupancy and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_flush) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_push) r_wr  <= r_wr + 3'd1;
        if (w_pop)  r_rd  <= r_rd + 3'd1;
        if (w_drop) r_ovf <= 1'b1;
      end
    end
  end

  // Registered read data and interrupt (irq tracks the post-edge count).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      irq <= 1'b0;
    end else begin
      if (w_rd) q <= w_rdata;
      irq <= (w_count_nxt != 4'd0);
    end
  end

endmodule

// File: tb/tb_keypad_reader.sv
// Directed, table-driven bench for keypad_reader with DEBOUNCE_CYCLES=4.
module tb_keypad_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic [15:0] addr;
  logic        we;
  logic        en;
  logic [3:0]  buttons_n;
  logic [15:0] q;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } bus_vec_t;

  bus_vec_t tab4 [14];

  always #5 clk = ~clk;

  keypad_reader #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data(data),
    .addr(addr),
    .we(we),
    .en(en),
    .buttons_n(buttons_n),
    .q(q),
    .irq(irq)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All bus tasks start and end at a falling edge.
  task automatic bus_read(input logic [2:0] a, output logic [15:0] v);
    en = 1'b1; we = 1'b0; addr = {5'b10101, a, 8'h3C}; data = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    v = q;
    en = 1'b0; addr = '0; data = '0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    en = 1'b1; we = 1'b1; addr = {5'b01010, a, 8'hC3}; data = d;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0; we = 1'b0; addr = '0; data = '0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] v;
    bus_read(a, v);
    check(name, v, exp);
  endtask

  task automatic wait_irq(input int max, output int cyc);
    cyc = max + 1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (irq) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic press(input int b, input int hold);
    buttons_n[b] = 1'b0;
    repeat (hold) @(negedge clk);
    buttons_n[b] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          irq_seen;
    logic [15:0] v;

    tab4[0]  = '{1'b0, 3'd1, 16'h0000, 16'h000A};
    tab4[1]  = '{1'b0, 3'd0, 16'h0000, 16'h000A};
    tab4[2]  = '{1'b0, 3'd2, 16'h0000, 16'h0002};
    tab4[3]  = '{1'b0, 3'd3, 16'h0000, 16'h8001};
    tab4[4]  = '{1'b0, 3'd3, 16'h0000, 16'h8003};
    tab4[5]  = '{1'b0, 3'd3, 16'h0000, 16'h0000};
    tab4[6]  = '{1'b0, 3'd2, 16'h0000, 16'h0000};
    tab4[7]  = '{1'b1, 3'd1, 16'h0008, 16'h0000};
    tab4[8]  = '{1'b0, 3'd1, 16'h0000, 16'h0002};
    tab4[9]  = '{1'b1, 3'd4, 16'h000F, 16'h0000};
    tab4[10] = '{1'b0, 3'd5, 16'h0000, 16'h0000};
    tab4[11] = '{1'b0, 3'd1, 16'h0000, 16'h0002};
    tab4[12] = '{1'b1, 3'd0, 16'hFFFF, 16'h0000};
    tab4[13] = '{1'b0, 3'd0, 16'h0000, 16'h000A};

    rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = '0; data = '0; buttons_n = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_q", q, 16'h0000);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("rst_stable", 3'd0, 16'h0000);
    rd_chk("rst_flag", 3'd1, 16'h0000);
    rd_chk("rst_count", 3'd2, 16'h0000);

    // Clean press of button 2: irq 8 cycles after the edge.
    buttons_n = 4'b1011;
    wait_irq(30, cyc);
    check("press2_latency", 16'(cyc), 16'd8);
    rd_chk("press2_pop", 3'd3, 16'h8002);
    rd_chk("press2_pop_empty", 3'd3, 16'h0000);
    check("press2_irq_low", {15'b0, irq}, 16'h0000);
    buttons_n = 4'hF;
    repeat (10) @(negedge clk);
    rd_chk("press2_released", 3'd0, 16'h0000);
    rd_chk("press2_flag", 3'd1, 16'h0004);
    bus_write(3'd1, 16'h000F);
    rd_chk("press2_flag_clr", 3'd1, 16'h0000);

    // Glitch of 3 cycles is rejected.
    irq_seen = 0;
    buttons_n = 4'b1110;
    repeat (3) begin @(negedge clk); if (irq) irq_seen++; end
    buttons_n = 4'hF;
    repeat (20) begin @(negedge clk); if (irq) irq_seen++; end
    check("glitch_irq", 16'(irq_seen), 16'd0);
    rd_chk("glitch_stable", 3'd0, 16'h0000);
    rd_chk("glitch_flag", 3'd1, 16'h0000);
    rd_chk("glitch_count", 3'd2, 16'h0000);

    // A pulse of exactly DEBOUNCE_CYCLES is accepted.
    buttons_n = 4'b1110;
    repeat (4) @(negedge clk);
    buttons_n = 4'hF;
    wait_irq(12, cyc);
    check("pulse4_irq", {15'b0, (cyc <= 12)}, 16'h0001);
    rd_chk("pulse4_pop", 3'd3, 16'h8000);
    bus_write(3'd1, 16'h000F);
    repeat (10) @(negedge clk);

    // Simultaneous press of buttons 3 and 1.
    buttons_n = 4'b0101;
    wait_irq(30, cyc);
    check("dual_latency", 16'(cyc), 16'd8);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      if (tab4[i].wr) begin
        bus_write(tab4[i].a, tab4[i].d);
      end else begin
        bus_read(tab4[i].a, v);
        check($sformatf("dual_vec%0d", i), v, tab4[i].exp);
      end
    end
    check("dual_irq_low", {15'b0, irq}, 16'h0000);
    buttons_n = 4'hF;
    repeat (10) @(negedge clk);
    rd_chk("dual_released", 3'd0, 16'h0000);

    // Overflow: nine presses, no pops.
    for (int i = 0; i < 9; i++) press(i % 4, 10);
    rd_chk("ovf_status", 3'd2, 16'h0018);
    check("ovf_irq", {15'b0, irq}, 16'h0001);
    rd_chk("ovf_first_pop", 3'd3, 16'h8000);
    rd_chk("ovf_after_pop", 3'd2, 16'h0017);
    rd_chk("ovf_second_pop", 3'd3, 16'h8001);
    bus_write(3'd2, 16'h0001);
    rd_chk("ovf_flushed", 3'd2, 16'h0000);
    check("ovf_irq_low", {15'b0, irq}, 16'h0000);
    rd_chk("ovf_pop_empty", 3'd3, 16'h0000);

    // Push/pop collision with one entry queued.
    buttons_n[0] = 1'b0;
    wait_irq(30, cyc);
    check("coll_first_irq", {15'b0, (cyc <= 30)}, 16'h0001);
    buttons_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    buttons_n[3] = 1'b0;
    repeat (7) @(negedge clk);
    bus_read(3'd3, v);
    check("coll_pop_old", v, 16'h8000);
    rd_chk("coll_count", 3'd2, 16'h0001);
    check("coll_irq", {15'b0, irq}, 16'h0001);
    rd_chk("coll_pop_new", 3'd3, 16'h8003);
    check("coll_irq_low", {15'b0, irq}, 16'h0000);
    buttons_n = 4'hF;
    repeat (10) @(negedge clk);

    // Reset asserted mid-run discards everything.
    bus_write(3'd1, 16'h000F);
    buttons_n[1] = 1'b0;
    wait_irq(30, cyc);
    check("midrst_irq_pre", {15'b0, (cyc <= 30)}, 16'h0001);
    rd_chk("midrst_flag_pre", 3'd1, 16'h0002);
    buttons_n = 4'hF;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_q", q, 16'h0000);
    check("midrst_irq", {15'b0, irq}, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rd_chk("midrst_count", 3'd2, 16'h0000);
    rd_chk("midrst_flag", 3'd1, 16'h0000);
    rd_chk("midrst_pop", 3'd3, 16'h0000);
    check("midrst_irq_after", {15'b0, irq}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
